// File: rtl/dataflow_fifo_pkg.sv
// Shared defaults and width helpers for the dataflow FIFO and the async_operator benches.
package dataflow_fifo_pkg;

    localparam int default_data_width = 8;
    localparam int default_depth      = 4;

    // Occupancy runs 0..n inclusive, so it needs one more code than n.
    function automatic int count_bits(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dataflow_fifo_if.sv
// Handshake bundle between the FIFO and its upstream/downstream neighbours.
interface dataflow_fifo_if
    import dataflow_fifo_pkg::*;
#(
    parameter int data_width = default_data_width,
    parameter int depth      = default_depth
);

    logic                         req_l;
    logic                         ack_l;
    logic [data_width-1:0]        din;
    logic                         req_r;
    logic                         ack_r;
    logic [data_width-1:0]        dout;
    logic [count_bits(depth)-1:0] count;
    logic                         err;

    modport slave (
        output req_l, ack_r, dout, count, err,
        input  ack_l, din, req_r
    );

    modport master (
        input  req_l, ack_r, dout, count, err,
        output ack_l, din, req_r
    );

endinterface

// File: rtl/dataflow_fifo_mem.sv
// Token storage: one synchronous write port, one combinational read port, no reset.
module dataflow_fifo_mem
    import dataflow_fifo_pkg::*;
#(
    parameter int data_width = default_data_width,
    parameter int depth      = default_depth
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [ptr_bits(depth)-1:0]   waddr,
    input  logic [data_width-1:0]        wdata,
    input  logic [ptr_bits(depth)-1:0]   raddr,
    output logic [data_width-1:0]        rdata
);

    logic [data_width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dataflow_fifo.sv
// Dataflow edge buffer: consumes tokens via req_l/ack_l, produces them via req_r/ack_r.
module dataflow_fifo
    import dataflow_fifo_pkg::*;
#(
    parameter int                    data_width    = default_data_width,
    parameter int                    depth         = default_depth,
    parameter logic [data_width-1:0] initial_value = '0
) (
    input  logic           clk,
    input  logic           rst,
    dataflow_fifo_if.slave bus
);

    localparam int ptr_width = ptr_bits(depth);
    localparam int cnt_width = count_bits(depth);
    localparam logic [cnt_width-1:0] full_count = cnt_width'(depth);
    localparam logic [ptr_width-1:0] last_ptr   = ptr_width'(depth - 1);

    logic [ptr_width-1:0]  wr_ptr;
    logic [ptr_width-1:0]  rd_ptr;
    logic [cnt_width-1:0]  count_q;
    logic [cnt_width-1:0]  next_count;
    logic                  req_l_q;
    logic                  ack_r_q;
    logic [data_width-1:0] dout_q;
    logic                  err_q;
    logic                  push;
    logic                  pop;
    logic                  overflow;
    logic [data_width-1:0] head;

    dataflow_fifo_mem #(
        .data_width (data_width),
        .depth      (depth)
    ) u_mem (
        .clk   (clk),
        .we    (push & rst),
        .waddr (wr_ptr),
        .wdata (bus.din),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // A pop needs a token already stored, so a same-cycle push never bypasses to dout.
    always_comb begin
        push       = bus.ack_l && (count_q != full_count);
        overflow   = bus.ack_l && (count_q == full_count);
        pop        = (count_q != '0) && bus.req_r && !ack_r_q;
        next_count = count_q;
        if (push && !pop) begin
            next_count = count_q + cnt_width'(1);
        end else if (pop && !push) begin
            next_count = count_q - cnt_width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            req_l_q <= 1'b0;
            ack_r_q <= 1'b0;
            dout_q  <= initial_value;
            err_q   <= 1'b0;
        end else begin
            count_q <= next_count;
            req_l_q <= !bus.ack_l && (next_count != full_count);
            ack_r_q <= pop;
            if (overflow) begin
                err_q <= 1'b1;
            end
            if (push) begin
                wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + ptr_width'(1);
            end
            if (pop) begin
                dout_q <= head;
                rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + ptr_width'(1);
            end
        end
    end

    assign bus.req_l = req_l_q;
    assign bus.ack_r = ack_r_q;
    assign bus.dout  = dout_q;
    assign bus.count = count_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_dataflow_fifo.sv
// Directed bench for dataflow_fifo: fill/drain, no-bypass latency, simultaneous push/pop,
// overflow, mid-stream reset and a long wrapping stream.
module tb_dataflow_fifo;

    localparam logic [7:0] init_val   = 8'h3C;
    localparam int         stream_len = 300;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [7:0] exp_q [$];
    logic prev_ack;
    logic seen;
    logic got;

    dataflow_fifo_if #(.data_width(8), .depth(4)) bus ();

    dataflow_fifo #(
        .data_width    (8),
        .depth         (4),
        .initial_value (init_val)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    // Acknowledge one token, honouring the upstream contract on req_l/ack_l history.
    task automatic applyStimulus(input logic [7:0] value);
        logic ready;
        ready = 1'b0;
        for (int c = 0; c < 30 && !ready; c++) begin
            @(negedge clk);
            if (bus.req_l && !bus.ack_l) ready = 1'b1;
        end
        if (!ready) begin
            checkOutput("push_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
            bus.ack_l = 1'b1;
            bus.din   = value;
            @(posedge clk);
            #1;
            bus.ack_l = 1'b0;
        end
    endtask

    task automatic drainQueue(input string tag);
        logic hit;
        bus.req_r = 1'b1;
        while (exp_q.size() > 0) begin
            hit = 1'b0;
            for (int c = 0; c < 20 && !hit; c++) begin
                @(negedge clk);
                if (bus.ack_r) hit = 1'b1;
            end
            if (!hit) begin
                checkOutput({tag, "_timeout"}, 0, 1);
                exp_q.delete();
            end else begin
                checkOutput(tag, bus.dout, exp_q.pop_front());
                if (exp_q.size() == 0) bus.req_r = 1'b0;
                @(negedge clk);
                checkOutput({tag, "_gap"}, bus.ack_r, 0);
            end
        end
        bus.req_r = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        prev_ack = 1'b0;
        bus.ack_l = 1'b0;
        bus.din   = '0;
        bus.req_r = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_req_l", bus.req_l, 0);
        checkOutput("rst_ack_r", bus.ack_r, 0);
        checkOutput("rst_dout", bus.dout, init_val);
        checkOutput("rst_count", bus.count, 0);
        checkOutput("rst_err", bus.err, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("req_l_after_rst", bus.req_l, 1);

        for (int i = 0; i < 4; i++) applyStimulus(8'(10 + i));
        @(negedge clk);
        checkOutput("fill_count", bus.count, 4);
        checkOutput("fill_req_l", bus.req_l, 0);
        checkOutput("fill_err", bus.err, 0);
        repeat (3) @(negedge clk);
        checkOutput("full_req_l_held", bus.req_l, 0);
        checkOutput("full_dout_held", bus.dout, init_val);

        exp_q = '{8'd10, 8'd11, 8'd12, 8'd13};
        drainQueue("drain");
        checkOutput("drain_count", bus.count, 0);
        bus.req_r = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | bus.ack_r;
        end
        bus.req_r = 1'b0;
        checkOutput("empty_no_ack", seen, 0);
        checkOutput("empty_dout_held", bus.dout, 13);

        // Push into an empty buffer with downstream already requesting.
        bus.req_r = 1'b1;
        applyStimulus(8'd20);
        @(negedge clk);
        checkOutput("nobypass_count", bus.count, 1);
        checkOutput("nobypass_ack_early", bus.ack_r, 0);
        @(negedge clk);
        bus.req_r = 1'b0;
        checkOutput("nobypass_ack", bus.ack_r, 1);
        checkOutput("nobypass_dout", bus.dout, 20);
        checkOutput("nobypass_count_after", bus.count, 0);

        applyStimulus(8'd30);
        applyStimulus(8'd31);
        got = 1'b0;
        for (int c = 0; c < 30 && !got; c++) begin
            @(negedge clk);
            if (bus.req_l && !bus.ack_l) got = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.ack_l = 1'b1;
        bus.din   = 8'd32;
        bus.req_r = 1'b1;
        @(posedge clk);
        #1;
        bus.ack_l = 1'b0;
        bus.req_r = 1'b0;
        @(negedge clk);
        checkOutput("simul_count", bus.count, 2);
        checkOutput("simul_ack", bus.ack_r, 1);
        checkOutput("simul_dout", bus.dout, 30);
        exp_q = '{8'd31, 8'd32};
        drainQueue("simul_drain");

        for (int i = 0; i < 4; i++) applyStimulus(8'(40 + i));
        @(posedge clk);
        #1;
        bus.ack_l = 1'b1;
        bus.din   = 8'd99;
        @(posedge clk);
        #1;
        bus.ack_l = 1'b0;
        @(negedge clk);
        checkOutput("ovf_err", bus.err, 1);
        checkOutput("ovf_count", bus.count, 4);
        repeat (3) @(negedge clk);
        checkOutput("ovf_err_sticky", bus.err, 1);
        exp_q = '{8'd40, 8'd41, 8'd42, 8'd43};
        drainQueue("ovf_drain");
        checkOutput("ovf_err_after_drain", bus.err, 1);
        checkOutput("ovf_count_after_drain", bus.count, 0);

        for (int i = 0; i < 3; i++) applyStimulus(8'(50 + i));
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkOutput("midrst_req_l", bus.req_l, 0);
        checkOutput("midrst_ack_r", bus.ack_r, 0);
        checkOutput("midrst_dout", bus.dout, init_val);
        checkOutput("midrst_count", bus.count, 0);
        checkOutput("midrst_err", bus.err, 0);
        bus.ack_l = 1'b1;
        bus.din   = 8'd77;
        repeat (2) @(negedge clk);
        bus.ack_l = 1'b0;
        checkOutput("midrst_ack_l_ignored", bus.count, 0);
        rst = 1'b1;
        bus.req_r = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_req_l_release", bus.req_l, 1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | bus.ack_r;
        end
        bus.req_r = 1'b0;
        checkOutput("midrst_no_stale_ack", seen, 0);
        checkOutput("midrst_count_after", bus.count, 0);

        fork
            begin
                for (int i = 0; i < stream_len; i++) applyStimulus(8'(i % 256));
            end
            begin
                bus.req_r = 1'b1;
                prev_ack  = 1'b0;
                for (int n = 0; n < stream_len; n++) begin
                    got = 1'b0;
                    for (int c = 0; c < 30 && !got; c++) begin
                        @(negedge clk);
                        if (bus.ack_r) begin
                            got = 1'b1;
                            checkOutput("stream_gap", prev_ack, 0);
                            checkOutput("stream_data", bus.dout, n % 256);
                        end
                        prev_ack = bus.ack_r;
                    end
                    if (!got) begin
                        checkOutput("stream_timeout", 0, 1);
                        break;
                    end
                end
                bus.req_r = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        checkOutput("stream_count_end", bus.count, 0);
        checkOutput("stream_err_end", bus.err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
